// File: rtl/card_dealer.sv
// card_dealer: draws one card without replacement from a single 52-card deck
// and delivers its blackjack point value (ace = 1, 2..9, ten/J/Q/K = 10).
// A free-running 8-bit LFSR picks the starting deck index for each deal. From
// there the scan walks forward, wrapping 51 -> 0, until it finds an undealt card.
//
// Parameters
//   SEED           LFSR reset value (must be nonzero)
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   deal_req       request one card (sampled only while idle)
//   deal_to_dealer destination tag captured with deal_req (1 = dealer)
//   shuffle        return all 52 cards to the deck (any state)
//   card_value     point value of the last delivered card, 1..10, held
//   card_to_dealer captured destination tag of the last delivered card
//   card_valid     one-cycle pulse when card_value/card_to_dealer are new
//   busy           high while a deal is in flight
//   cards_left     undealt cards, 0..52
//   deck_empty     cards_left == 0
module card_dealer #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_req,
  input  logic       deal_to_dealer,
  input  logic       shuffle,
  output logic [7:0] card_value,
  output logic       card_to_dealer,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDeliver
  } state_e;

  state_e      state_q;
  logic [51:0] used_q;
  logic [5:0]  idx_q;
  logic [7:0]  lfsr_q;
  logic        tag_q;
  logic [5:0]  start_idx;

  // Point value of deck index i: rank = (i mod 13) + 1, faces count as 10.
  function automatic logic [3:0] card_val(input logic [5:0] i);
    logic [5:0] r;
    if (i >= 6'd39) begin
      r = i - 6'd39;
    end else if (i >= 6'd26) begin
      r = i - 6'd26;
    end else if (i >= 6'd13) begin
      r = i - 6'd13;
    end else begin
      r = i;
    end
    // r is rank - 1 here, so r >= 10 means J/Q/K
    card_val = (r >= 6'd10) ? 4'd10 : (r[3:0] + 4'd1);
  endfunction

  // Fold the 6 low LFSR bits into 0..51.
  always_comb begin
    start_idx = lfsr_q[5:0];
    if (lfsr_q[5:0] >= 6'd52) begin
      start_idx = lfsr_q[5:0] - 6'd52;
    end
  end

  assign busy       = (state_q != StIdle);
  assign deck_empty = (cards_left == 6'd0);

  // Free-running: advances every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      used_q         <= '0;
      cards_left     <= 6'd52;
      idx_q          <= '0;
      tag_q          <= 1'b0;
      card_value     <= '0;
      card_to_dealer <= 1'b0;
      card_valid     <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (shuffle) begin
            used_q     <= '0;
            cards_left <= 6'd52;
          end else if (deal_req && !deck_empty) begin
            tag_q   <= deal_to_dealer;
            idx_q   <= start_idx;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (shuffle) begin
            // In-flight deal is abandoned; no pulse follows.
            used_q     <= '0;
            cards_left <= 6'd52;
            state_q    <= StIdle;
          end else if (!used_q[idx_q]) begin
            used_q[idx_q]  <= 1'b1;
            card_value     <= {4'b0000, card_val(idx_q)};
            card_to_dealer <= tag_q;
            cards_left     <= cards_left - 6'd1;
            // Registered pulse is high for exactly the deliver cycle.
            card_valid     <= 1'b1;
            state_q        <= StDeliver;
          end else begin
            idx_q <= (idx_q == 6'd51) ? 6'd0 : (idx_q + 6'd1);
          end
        end
        StDeliver: begin
          state_q <= StIdle;
          // The pulse is already out; the delivered card goes back too.
          if (shuffle) begin
            used_q     <= '0;
            cards_left <= 6'd52;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  localparam logic [7:0] SEED = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       deal_req = 1'b0;
  logic       deal_to_dealer = 1'b0;
  logic       shuffle = 1'b0;
  logic [7:0] card_value;
  logic       card_to_dealer;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_empty;

  card_dealer #(.SEED(SEED)) dut (
    .clk           (clk),
    .rst           (rst),
    .deal_req      (deal_req),
    .deal_to_dealer(deal_to_dealer),
    .shuffle       (shuffle),
    .card_value    (card_value),
    .card_to_dealer(card_to_dealer),
    .card_valid    (card_valid),
    .busy          (busy),
    .cards_left    (cards_left),
    .deck_empty    (deck_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: deck as a plain array of dealt flags.
  bit   m_used[52];
  int   m_left;
  logic [7:0] m_lfsr;
  int   last_val;
  int   last_lat;

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int val_of(input int i);
    int r;
    r = (i % 13) + 1;
    return (r > 10) ? 10 : r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  // One deal starting at a negedge in an idle cycle. Returns at the negedge
  // of the first idle cycle after delivery. With hold, deal_req stays high.
  task automatic do_deal(input logic tag, input bit hold);
    int start, n, idx, lat;
    start = int'(m_lfsr[5:0]) % 52;
    n = 0;
    while (m_used[(start + n) % 52] && n < 52) n++;
    idx = (start + n) % 52;
    deal_req = 1'b1;
    deal_to_dealer = tag;
    @(negedge clk);
    if (!hold) deal_req = 1'b0;
    deal_to_dealer = ~tag;  // must already be captured
    check("busy_after_accept", busy, 1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (card_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    last_lat = lat;
    last_val = int'(card_value);
    check("deal_latency", lat, 2 + n);
    check("card_value", int'(card_value), val_of(idx));
    check("card_to_dealer", card_to_dealer, tag);
    check("cards_left_at_valid", cards_left, m_left - 1);
    check("deck_empty_at_valid", deck_empty, (m_left - 1) == 0);
    m_used[idx] = 1'b1;
    m_left--;
    @(negedge clk);
    check("busy_after_valid", busy, 0);
    check("valid_one_cycle", card_valid, 0);
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    clear_model();
  endtask

  typedef struct {
    bit deal;
    bit tag;
    bit shuf;
    int exp_left;
  } vec_t;

  vec_t vecs[7];
  int   hist[11];
  int   sum;
  int   rem;

  initial begin
    vecs[0] = '{deal: 1'b1, tag: 1'b0, shuf: 1'b0, exp_left: 51};
    vecs[1] = '{deal: 1'b1, tag: 1'b1, shuf: 1'b0, exp_left: 50};
    vecs[2] = '{deal: 1'b0, tag: 1'b0, shuf: 1'b1, exp_left: 52};
    vecs[3] = '{deal: 1'b1, tag: 1'b1, shuf: 1'b1, exp_left: 52};
    vecs[4] = '{deal: 1'b1, tag: 1'b0, shuf: 1'b0, exp_left: 51};
    vecs[5] = '{deal: 1'b1, tag: 1'b1, shuf: 1'b0, exp_left: 50};
    vecs[6] = '{deal: 1'b0, tag: 1'b0, shuf: 1'b1, exp_left: 52};

    clear_model();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", card_valid, 0);
    check("rst_cards_left", cards_left, 52);
    check("rst_deck_empty", deck_empty, 0);
    check("rst_card_value", card_value, 0);
    check("rst_card_to_dealer", card_to_dealer, 0);
    rst = 1'b1;
    @(negedge clk);

    // Scripted operations from a fresh deck.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].deal && !vecs[v].shuf) begin
        do_deal(vecs[v].tag, 1'b0);
      end else begin
        deal_req = vecs[v].deal;
        deal_to_dealer = vecs[v].tag;
        do_shuffle();
        deal_req = 1'b0;
        check("vec_busy", busy, 0);
        check("vec_valid", card_valid, 0);
        @(negedge clk);
        check("vec_no_late_valid", card_valid, 0);
      end
      check("vec_cards_left", cards_left, vecs[v].exp_left);
    end

    // Full deck with random tags and gaps.
    do_shuffle();
    for (int v = 1; v <= 10; v++) hist[v] = 0;
    sum = 0;
    for (int d = 0; d < 52; d++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_deal(1'($urandom_range(0, 1)), 1'b0);
      if (last_val >= 1 && last_val <= 10) hist[last_val]++;
      sum += last_val;
    end
    for (int v = 1; v <= 9; v++) check("hist_low", hist[v], 4);
    check("hist_ten", hist[10], 16);
    check("value_sum", sum, 340);
    check("empty_cards_left", cards_left, 0);
    check("empty_flag", deck_empty, 1);

    // Request on an empty deck is ignored.
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("empty_req_busy", busy, 0);
      check("empty_req_valid", card_valid, 0);
      @(negedge clk);
    end
    check("empty_req_cards_left", cards_left, 0);

    // 51 deals, then the last card.
    do_shuffle();
    for (int d = 0; d < 51; d++) do_deal(1'b0, 1'b0);
    rem = 0;
    for (int i = 0; i < 52; i++) if (!m_used[i]) rem = i;
    do_deal(1'b1, 1'b0);
    check("last_card_value", last_val, val_of(rem));
    check("last_card_latency_bound", last_lat >= 2 && last_lat <= 53, 1);
    check("last_card_empty", deck_empty, 1);

    // Shuffle while scanning drops the deal.
    do_shuffle();
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    check("scan_shuf_busy_before", busy, 1);
    do_shuffle();
    check("scan_shuf_busy", busy, 0);
    check("scan_shuf_valid", card_valid, 0);
    check("scan_shuf_cards_left", cards_left, 52);
    repeat (3) begin
      @(negedge clk);
      check("scan_shuf_no_valid", card_valid, 0);
    end

    // Asynchronous reset mid-scan after 10 deals.
    for (int d = 0; d < 10; d++) do_deal(1'(d & 1), 1'b0);
    deal_req = 1'b1;
    deal_to_dealer = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", card_valid, 0);
    check("arst_cards_left", cards_left, 52);
    check("arst_deck_empty", deck_empty, 0);
    check("arst_card_value", card_value, 0);
    check("arst_card_to_dealer", card_to_dealer, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("arst_no_stray_valid", card_valid, 0);
    end

    // deal_req held high across five deals, alternating tags.
    for (int d = 0; d < 5; d++) do_deal(1'(d & 1), 1'b1);
    deal_req = 1'b0;
    check("held_cards_left", cards_left, 47);
    @(negedge clk);
    check("held_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Card source for the blackjack datapath. On request it draws one card without replacement from a single 52-card deck, using an on-chip LFSR for randomness, and delivers the card's blackjack point value (ace = 1, 2..9, ten/J/Q/K = 10) on an 8-bit bus. The value feeds the hand evaluator's card inputs. Destination is tagged player or dealer. The block tracks used cards, reports remaining count, and reshuffles on command.

## Interface
- SEED, 8'h5A: LFSR reset value. Must be nonzero; zero is illegal.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (rst = 0 resets).
- deal_req  in  1  request one card; sampled only in IDLE.
- deal_to_dealer  in  1  destination tag captured with deal_req (0 = player, 1 = dealer).
- shuffle  in  1  return all 52 cards to the deck; any state.
- card_value  out  8  point value of delivered card, 1..10; holds until next delivery.
- card_to_dealer  out  1  captured destination tag of delivered card.
- card_valid  out  1  one-cycle pulse: card_value/card_to_dealer valid this cycle.
- busy  out  1  high whenever state ≠ IDLE.
- cards_left  out  6  undealt cards, 0..52.
- deck_empty  out  1  cards_left == 0 (combinational from counter).

## Operation
- Deck index i in 0..51: rank = (i mod 13) + 1; value = 10 if rank > 10, else rank. Each value 1..9 appears 4 times; value 10 appears 16 times.
- 52-bit used mask; bit i set once card i is dealt.
- LFSR is 8 bits and free-running (advances every cycle in every state): shift left, new bit0 = b7^b5^b4^b3.
- Start index = lfsr[5:0] if < 52, else lfsr[5:0] − 52. Uses the LFSR value present in the accepting cycle.
- States:
  - IDLE: shuffle → clear mask, cards_left = 52, stay IDLE. Else deal_req && !deck_empty → capture deal_to_dealer, idx = start index, → SCAN. deal_req while deck_empty is ignored: no pulse, no state change.
  - SCAN: shuffle → clear mask, cards_left = 52, → IDLE. The in-flight deal is dropped with no card_valid. Else, if used[idx] = 0: set used[idx], register card_value = value(idx) and card_to_dealer, cards_left −1, → DELIVER. Else idx = (idx == 51) ? 0 : idx + 1, stay SCAN.
  - DELIVER: card_valid = 1, → IDLE. A shuffle in this cycle still lets the pulse out, then clears the deck; the delivered card is returned.
- Scan wraps 51 → 0. It always terminates because entry requires cards_left ≥ 1.
- deal_req outside IDLE is ignored and not queued. Requesters wait for busy = 0.
- Width rules: cards_left never underflows below 0 or exceeds 52; card_value upper bits [7:4] are always 0.

## Timing
- Reset (rst = 0, async) values: state IDLE, used mask all 0, cards_left 52, deck_empty 0, lfsr = SEED, idx 0, card_value 0, card_to_dealer 0, card_valid 0, busy 0.
- Reset mid-operation aborts everything immediately. No card_valid follows release.
- Latency: deal_req high in cycle c (IDLE) → busy from c+1 → card_valid in cycle c+2+N, where N = used cards skipped (0..51). Worst case c+53.
- busy drops in the cycle after the card_valid cycle. The earliest next accepted deal_req is in that cycle.
- cards_left/deck_empty update in the same cycle card_valid rises.
- Shuffle takes effect on the edge ending its cycle. deal_req and shuffle together in IDLE: shuffle wins, deal dropped.

## Test plan
- Reset, deal_req one cycle → busy in c+1, card_valid exactly in c+2, card_value in 1..10, cards_left 51, card_to_dealer equals the tag presented.
- 52 back-to-back deals → 52 pulses, all 52 indices once (four each of 1..9, sixteen 10s, sum 340), cards_left 0, deck_empty 1. A 53rd deal_req gives no card_valid and busy stays 0.
- Deal 51 cards, then 1 more → card_valid within ≤ 53 cycles of the request, value equals the only remaining index's value, deck_empty 1.
- shuffle asserted during SCAN → no card_valid, IDLE next cycle, cards_left 52. shuffle + deal_req in the same IDLE cycle → no deal, cards_left 52.
- rst low for 1 cycle mid-SCAN after 10 deals → all outputs return to reset values asynchronously, cards_left 52, no stray card_valid.
- deal_req held high continuously for 5 deals → exactly one deal accepted per IDLE visit, requests while busy ignored, alternating deal_to_dealer reflected per card.
